// File: rtl/alarm_controller.sv
// Alarm time storage, alarm-vs-clock compare and the ring / snooze / timeout FSM
// for the digital alarm clock. All status outputs are registered copies of the next state.
module alarm_controller #(
  parameter int RING_TIMEOUT = 60,
  parameter int SNOOZE_MIN   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] cur_sec_u,
  input  logic [2:0] cur_sec_t,
  input  logic [3:0] cur_min_u,
  input  logic [2:0] cur_min_t,
  input  logic [3:0] cur_hr_u,
  input  logic [1:0] cur_hr_t,
  input  logic       alarm_arm,
  input  logic       set_mode,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       stop,
  input  logic       snooze,
  output logic [3:0] al_min_u,
  output logic [2:0] al_min_t,
  output logic [3:0] al_hr_u,
  output logic [1:0] al_hr_t,
  output logic       setting,
  output logic       ringing,
  output logic       snoozing,
  output logic       missed
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SET    = 2'd1,
    S_RING   = 2'd2,
    S_SNOOZE = 2'd3
  } state_e;

  localparam logic [7:0]  RING_LAST   = 8'(RING_TIMEOUT - 1);
  localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * 60);

  state_e      state_q, state_d;
  logic [7:0]  ring_cnt_q, ring_cnt_d;
  logic [11:0] snz_cnt_q, snz_cnt_d;
  logic        match_d_q;
  logic        missed_q, missed_d;
  logic [3:0]  al_min_u_q, al_min_u_d;
  logic [2:0]  al_min_t_q, al_min_t_d;
  logic [3:0]  al_hr_u_q, al_hr_u_d;
  logic [1:0]  al_hr_t_q, al_hr_t_d;
  logic        setting_q, setting_d;
  logic        ringing_q, ringing_d;
  logic        snoozing_q, snoozing_d;
  logic        match_s;
  logic        trigger_s;

  // BCD minute increment 00..59, wrapping without carry into the hours
  function automatic logic [6:0] bcd_inc_min(input logic [2:0] t, input logic [3:0] u);
    logic [6:0] r;
    if (u == 4'd9) begin
      r = (t == 3'd5) ? {3'd0, 4'd0} : {t + 3'd1, 4'd0};
    end else begin
      r = {t, u + 4'd1};
    end
    return r;
  endfunction

  // BCD hour increment 00..23
  function automatic logic [5:0] bcd_inc_hr(input logic [1:0] t, input logic [3:0] u);
    logic [5:0] r;
    if ((t == 2'd2) && (u == 4'd3)) begin
      r = {2'd0, 4'd0};
    end else if (u == 4'd9) begin
      r = {t + 2'd1, 4'd0};
    end else begin
      r = {t, u + 4'd1};
    end
    return r;
  endfunction

  assign match_s = (cur_hr_t == al_hr_t_q) && (cur_hr_u == al_hr_u_q) &&
                   (cur_min_t == al_min_t_q) && (cur_min_u == al_min_u_q) &&
                   (cur_sec_t == 3'd0) && (cur_sec_u == 4'd0);
  // Rising edge of match only, so a held alarm minute fires once
  assign trigger_s = match_s & ~match_d_q & alarm_arm;

  // State, counters, alarm digits and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ring_cnt_q <= 8'd0;
      snz_cnt_q  <= 12'd0;
      match_d_q  <= 1'b1;
      missed_q   <= 1'b0;
      al_min_u_q <= 4'd0;
      al_min_t_q <= 3'd0;
      al_hr_u_q  <= 4'd0;
      al_hr_t_q  <= 2'd0;
      setting_q  <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      match_d_q  <= match_s;
      missed_q   <= missed_d;
      al_min_u_q <= al_min_u_d;
      al_min_t_q <= al_min_t_d;
      al_hr_u_q  <= al_hr_u_d;
      al_hr_t_q  <= al_hr_t_d;
      setting_q  <= setting_d;
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
    end
  end

  // Next-state, counter and alarm-digit update logic
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    missed_d   = missed_q;
    al_min_u_d = al_min_u_q;
    al_min_t_d = al_min_t_q;
    al_hr_u_d  = al_hr_u_q;
    al_hr_t_d  = al_hr_t_q;
    case (state_q)
      S_IDLE: begin
        if (set_mode) begin
          state_d  = S_SET;
          missed_d = 1'b0;
        end else if (trigger_s) begin
          state_d    = S_RING;
          ring_cnt_d = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SET: begin
        {al_min_t_d, al_min_u_d} = inc_min ? bcd_inc_min(al_min_t_q, al_min_u_q)
                                           : {al_min_t_q, al_min_u_q};
        {al_hr_t_d, al_hr_u_d}   = inc_hr ? bcd_inc_hr(al_hr_t_q, al_hr_u_q)
                                          : {al_hr_t_q, al_hr_u_q};
        state_d = set_mode ? S_IDLE : S_SET;
      end
      S_RING: begin
        if (stop || !alarm_arm) begin
          state_d = S_IDLE;
        end else if (snooze) begin
          state_d   = S_SNOOZE;
          snz_cnt_d = SNOOZE_LOAD;
        end else if (en) begin
          if (ring_cnt_q == RING_LAST) begin
            state_d  = S_IDLE;
            missed_d = 1'b1;
          end else begin
            ring_cnt_d = ring_cnt_q + 8'd1;
          end
        end else begin
          state_d = S_RING;
        end
      end
      S_SNOOZE: begin
        if (stop || !alarm_arm) begin
          state_d = S_IDLE;
        end else if (en) begin
          if (snz_cnt_q == 12'd1) begin
            state_d    = S_RING;
            ring_cnt_d = 8'd0;
          end else begin
            snz_cnt_d = snz_cnt_q - 12'd1;
          end
        end else begin
          state_d = S_SNOOZE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status decode of the next state, registered alongside it
  always_comb begin
    setting_d  = 1'b0;
    ringing_d  = 1'b0;
    snoozing_d = 1'b0;
    case (state_d)
      S_SET:    setting_d  = 1'b1;
      S_RING:   ringing_d  = 1'b1;
      S_SNOOZE: snoozing_d = 1'b1;
      default: begin
        setting_d  = 1'b0;
        ringing_d  = 1'b0;
        snoozing_d = 1'b0;
      end
    endcase
  end

  assign al_min_u = al_min_u_q;
  assign al_min_t = al_min_t_q;
  assign al_hr_u  = al_hr_u_q;
  assign al_hr_t  = al_hr_t_q;
  assign setting  = setting_q;
  assign ringing  = ringing_q;
  assign snoozing = snoozing_q;
  assign missed   = missed_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed, table-driven bench for alarm_controller: one vector per clock,
// outputs sampled 1 time unit after the rising edge.
module tb_alarm_controller;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [19:0] cur;
    logic        arm;
    logic        set_mode;
    logic        inc_hr;
    logic        inc_min;
    logic        stop_p;
    logic        snooze_p;
    logic [12:0] exp_al;
    logic [3:0]  exp_fl;
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [3:0] cur_sec_u = 4'd0;
  logic [2:0] cur_sec_t = 3'd0;
  logic [3:0] cur_min_u = 4'd0;
  logic [2:0] cur_min_t = 3'd0;
  logic [3:0] cur_hr_u = 4'd0;
  logic [1:0] cur_hr_t = 2'd0;
  logic       alarm_arm = 1'b0;
  logic       set_mode = 1'b0;
  logic       inc_hr = 1'b0;
  logic       inc_min = 1'b0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic [3:0] al_min_u;
  logic [2:0] al_min_t;
  logic [3:0] al_hr_u;
  logic [1:0] al_hr_t;
  logic       setting, ringing, snoozing, missed;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  alarm_controller #(.RING_TIMEOUT(60), .SNOOZE_MIN(5)) dut (
    .clk(clk), .reset(reset), .en(en),
    .cur_sec_u(cur_sec_u), .cur_sec_t(cur_sec_t),
    .cur_min_u(cur_min_u), .cur_min_t(cur_min_t),
    .cur_hr_u(cur_hr_u), .cur_hr_t(cur_hr_t),
    .alarm_arm(alarm_arm), .set_mode(set_mode),
    .inc_hr(inc_hr), .inc_min(inc_min), .stop(stop), .snooze(snooze),
    .al_min_u(al_min_u), .al_min_t(al_min_t), .al_hr_u(al_hr_u), .al_hr_t(al_hr_t),
    .setting(setting), .ringing(ringing), .snoozing(snoozing), .missed(missed)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] tm(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [12:0] al(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  // flags are {setting, ringing, snoozing, missed}
  function automatic vec_t mk(input logic rst_n, input logic e, input logic [19:0] cur,
                              input logic arm, input logic sm, input logic ih, input logic im,
                              input logic sp, input logic sn, input int ah, input int am,
                              input logic [3:0] fl, input string nm);
    vec_t v;
    v.rst_n = rst_n; v.en = e; v.cur = cur; v.arm = arm; v.set_mode = sm;
    v.inc_hr = ih; v.inc_min = im; v.stop_p = sp; v.snooze_p = sn;
    v.exp_al = al(ah, am); v.exp_fl = fl; v.name = nm;
    return v;
  endfunction

  task automatic step(input vec_t v);
    logic [12:0] got_al;
    logic [3:0]  got_fl;
    @(negedge clk);
    reset = v.rst_n; en = v.en; alarm_arm = v.arm; set_mode = v.set_mode;
    inc_hr = v.inc_hr; inc_min = v.inc_min; stop = v.stop_p; snooze = v.snooze_p;
    {cur_hr_t, cur_hr_u, cur_min_t, cur_min_u, cur_sec_t, cur_sec_u} = v.cur;
    @(posedge clk);
    #1;
    got_al = {al_hr_t, al_hr_u, al_min_t, al_min_u};
    got_fl = {setting, ringing, snoozing, missed};
    n_vec++;
    if ((got_al !== v.exp_al) || (got_fl !== v.exp_fl)) begin
      n_err++;
      $display("FAIL %s (vec %0d): got al=%h flags=%b, expected al=%h flags=%b",
               v.name, n_vec, got_al, got_fl, v.exp_al, v.exp_fl);
    end
  endtask

  initial begin
    // Reset, then no spurious ring at 00:00:00 with the alarm armed
    vecs.push_back(mk(1'b0, 1'b0, tm(0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0000, "reset0"));
    vecs.push_back(mk(1'b0, 1'b0, tm(0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0000, "reset1"));
    vecs.push_back(mk(1'b1, 1'b0, tm(0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0000, "no_spurious0"));
    vecs.push_back(mk(1'b1, 1'b0, tm(0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0000, "no_spurious1"));
    // Set alarm to 07:13
    vecs.push_back(mk(1'b1, 1'b0, tm(12, 0, 30), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b1000, "enter_set"));
    for (int i = 1; i <= 13; i++)
      vecs.push_back(mk(1'b1, 1'b0, tm(12, 0, 30), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, i, 4'b1000, "inc_min"));
    for (int i = 1; i <= 7; i++)
      vecs.push_back(mk(1'b1, 1'b0, tm(12, 0, 30), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, i, 13, 4'b1000, "inc_hr"));
    vecs.push_back(mk(1'b1, 1'b0, tm(12, 0, 30), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0000, "leave_set"));
    vecs.push_back(mk(1'b1, 1'b0, tm(7, 12, 59), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0000, "pre_match"));
    vecs.push_back(mk(1'b1, 1'b1, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0100, "trigger"));
    vecs.push_back(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0100, "ring_hold"));
    vecs.push_back(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7, 13, 4'b0100, "ring_ignores_set"));
    foreach (vecs[i]) step(vecs[i]);

    // Timeout: ring counter starts at 0, 60th tick stops and sets missed
    for (int i = 1; i <= 59; i++)
      step(mk(1'b1, 1'b1, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0100, "ring_tick"));
    step(mk(1'b1, 1'b1, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0001, "timeout"));
    for (int i = 0; i < 3; i++)
      step(mk(1'b1, 1'b1, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0001, "idle_after_timeout"));

    // Snooze for 300 ticks, then ring again, then stop
    step(mk(1'b1, 1'b0, tm(7, 12, 59), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0001, "rearm_pre"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0101, "retrigger"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 13, 4'b0011, "snooze"));
    for (int i = 1; i <= 299; i++)
      step(mk(1'b1, 1'b1, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0011, "snooze_tick"));
    step(mk(1'b1, 1'b1, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0101, "snooze_expire"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7, 13, 4'b0001, "stop"));

    // Stop and snooze together in RING
    step(mk(1'b1, 1'b0, tm(7, 12, 59), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0001, "pre2"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0101, "trig2"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7, 13, 4'b0001, "stop_and_snooze"));

    // Disarm during SNOOZE
    step(mk(1'b1, 1'b0, tm(7, 12, 59), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0001, "pre3"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0101, "trig3"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 13, 4'b0011, "snooze3"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0001, "disarm_snooze"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0001, "rearm_no_ring"));

    // Trigger and set_mode together: SET wins, missed clears, leaving SET on a match stays quiet
    step(mk(1'b1, 1'b0, tm(7, 12, 59), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0001, "pre4"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b1000, "trig_vs_set"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7, 13, 4'b1000, "set_ignores_stop"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0000, "leave_set_on_match"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b0000, "still_idle"));

    // BCD roll-overs in SET: 09->10, 19->20, 23:59 -> 00:00, 59 -> 00 without hour carry
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7, 13, 4'b1000, "enter_set2"));
    for (int h = 8; h <= 23; h++)
      step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, h, 13, 4'b1000, "hr_roll"));
    for (int m = 14; m <= 59; m++)
      step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 23, m, 4'b1000, "min_roll"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 4'b1000, "both_2359"));
    for (int m = 1; m <= 59; m++)
      step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, m, 4'b1000, "min_count"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 4'b1000, "min_59_no_carry"));
    step(mk(1'b1, 1'b0, tm(7, 13, 0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0000, "leave_set2"));

    // Reset while ringing
    step(mk(1'b1, 1'b0, tm(23, 59, 59), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0000, "pre5"));
    step(mk(1'b1, 1'b0, tm(0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0100, "trig_midnight"));
    step(mk(1'b0, 1'b0, tm(0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0000, "reset_mid_ring"));
    step(mk(1'b1, 1'b0, tm(0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0000, "no_ring_after_reset"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Downstream consumer of the BCD time-of-day counter (sec/min/hour digits) in the digital alarm clock.
- Holds a user-set alarm time, edited with hour/minute increment buttons.
- Compares the alarm time against the live counter digits and runs the ring / snooze / timeout state machine.
- Drives the buzzer and the alarm digits used by the display mux.

Parameters:
- RING_TIMEOUT, 60, number of en ticks (seconds) the alarm rings unattended before auto-stopping; range 1..255.
- SNOOZE_MIN, 5, snooze duration in minutes; range 1..59. Countdown length is SNOOZE_MIN*60 en ticks.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge; 0 = reset.
- en  in  1  1 Hz tick, one clk cycle wide; the same enable that drives the time counter.
- cur_sec_u  in  4  current seconds units, BCD 0..9.
- cur_sec_t  in  3  current seconds tens, 0..5.
- cur_min_u  in  4  current minutes units, 0..9.
- cur_min_t  in  3  current minutes tens, 0..5.
- cur_hr_u  in  4  current hours units, 0..9.
- cur_hr_t  in  2  current hours tens, 0..2.
- alarm_arm  in  1  level; 1 = alarm armed.
- set_mode  in  1  single-cycle pulse (debounced upstream); toggles alarm-set mode.
- inc_hr  in  1  single-cycle pulse; increments alarm hour while in SET.
- inc_min  in  1  single-cycle pulse; increments alarm minute while in SET.
- stop  in  1  single-cycle pulse; silences the alarm.
- snooze  in  1  single-cycle pulse; defers the alarm.
- al_min_u  out  4  stored alarm minutes units.
- al_min_t  out  3  stored alarm minutes tens.
- al_hr_u  out  4  stored alarm hours units.
- al_hr_t  out  2  stored alarm hours tens.
- setting  out  1  1 while in SET.
- ringing  out  1  1 while in RING; drives the buzzer.
- snoozing  out  1  1 while in SNOOZE.
- missed  out  1  sticky; set when RING times out.

Behaviour:
- Reset (reset==0 at clk edge):
  - State goes to IDLE.
  - All alarm digits 0 (alarm 00:00).
  - setting, ringing, snoozing and missed are 0.
  - Ring and snooze counters are 0; match_d is 1 (this blocks a spurious trigger at 00:00:00 straight after reset).
  - Reset mid-operation aborts ringing or snooze on the next edge.
- Match:
  - match is combinational: cur hr/min digits equal the alarm digits and cur_sec_t==0 and cur_sec_u==0.
  - match_d registers match every cycle.
  - trigger = match & ~match_d & alarm_arm. Exactly one trigger occurs per alarm minute.
- All outputs are registered and decoded from the state register; transitions take effect on the next clk edge.
- IDLE:
  - set_mode -> SET; this has priority over a trigger in the same cycle, and that trigger is lost.
  - trigger -> RING, ring counter cleared.
  - The missed flag clears on entry to SET.
- SET:
  - inc_min: BCD minute increment, 09->10, 59->00, no carry into hours.
  - inc_hr: 09->10, 19->20, 23->00.
  - inc_hr and inc_min in the same cycle are both applied.
  - set_mode -> IDLE.
  - stop, snooze and trigger are ignored; match_d keeps updating, so leaving SET while match is 1 does not ring.
- RING, in priority order:
  1. stop or alarm_arm==0 -> IDLE.
  2. snooze -> SNOOZE; snooze counter loaded with SNOOZE_MIN*60.
  3. en with ring counter == RING_TIMEOUT-1 -> IDLE, missed set to 1.
  4. Otherwise en increments the ring counter.
  - set_mode, inc_hr and inc_min are ignored.
- SNOOZE:
  - stop or alarm_arm==0 -> IDLE.
  - en decrements the snooze counter; en with counter==1 -> RING, ring counter cleared.
  - snooze, set_mode and new triggers are ignored.
- Counter widths: ring counter 8 bits; snooze counter 12 bits (max 3540).
- Out-of-range BCD on the cur_* inputs only affects the compare; no checking is done.

Test Plan:
- Reset low 2 cycles -> all outputs 0, alarm digits 00:00; hold cur time 00:00:00 after release -> ringing stays 0.
- In SET: 13 inc_min pulses then 7 inc_hr pulses, set_mode, arm=1 -> alarm 07:13; drive cur 07:12:59 then en -> 07:13:00 -> ringing=1 on the next edge, exactly one entry into RING.
- In RING, issue 60 en pulses with no button presses -> ringing drops on the 60th tick, missed=1; stays in IDLE while 07:13:xx persists.
- In RING, snooze pulse -> snoozing=1; after 299 en pulses still snoozing; the 300th en -> ringing=1. stop pulse -> IDLE, ringing=0.
- In SET at alarm 23:59: inc_min and inc_hr in the same cycle -> 00:00. inc_hr from 09 -> 10, from 19 -> 20.
- Simultaneous events:
  - In RING, stop and snooze in the same cycle -> IDLE.
  - In IDLE, trigger and set_mode in the same cycle -> SET, ringing=0.
  - Drop alarm_arm during SNOOZE -> IDLE.
